// File: rtl/pad_seq_pkg.sv
// pad_seq_pkg: shared defaults and FSM state encoding for the pad sequencer.
//   DEPTH_DEF      default number of sequence entries
//   DEB_CYCLES_DEF default debounce length in synchronized samples
//   state_t        sequencer FSM states
package pad_seq_pkg;
    localparam int DEPTH_DEF      = 16;
    localparam int DEB_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;
endpackage

// File: rtl/pad_debounce.sv
// pad_debounce: 2-flop synchronizer plus press/release debouncer for the pad encoder.
//   clk, rst_n  clock and asynchronous active-low reset
//   pad_hit     raw any-pad flag (asynchronous)
//   pad_code    raw 4-bit pad index (asynchronous)
//   press       one-cycle pulse when a debounced press is accepted
//   press_code  synchronized pad index
module pad_debounce import pad_seq_pkg::*; #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_hit,
    input  logic [3:0] pad_code,
    output logic       press,
    output logic [3:0] press_code
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d;
    logic [3:0]    code_s1_q, code_s1_d, code_s2_q, code_s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // level_q is the accepted pad level; cnt_q counts consecutive synchronized
    // samples that disagree with it, so presses and releases share one counter.
    always_comb begin
        hit_s1_d  = pad_hit;
        hit_s2_d  = hit_s1_q;
        code_s1_d = pad_code;
        code_s2_d = code_s1_q;
        level_d   = level_q;
        press_d   = 1'b0;
        cnt_d     = (hit_s2_q != level_q) ? cnt_q + CW'(1) : '0;
        if (cnt_d == CW'(DEB_CYCLES)) begin
            level_d = hit_s2_q;
            press_d = hit_s2_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_s1_q  <= 1'b0;
            hit_s2_q  <= 1'b0;
            code_s1_q <= '0;
            code_s2_q <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            hit_s1_q  <= hit_s1_d;
            hit_s2_q  <= hit_s2_d;
            code_s1_q <= code_s1_d;
            code_s2_q <= code_s2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
        end
    end

    assign press      = press_q;
    assign press_code = code_s2_q;
endmodule

// File: rtl/pad_sequencer.sv
// pad_sequencer: records debounced pad presses into a sequence and plays them back on tempo ticks.
//   clk, rst_n  clock and asynchronous active-low reset
//   pad_code    pad index from encoder; pad_hit any-pad flag (both asynchronous)
//   rec_en      level request for record mode
//   play_req    pulse starting playback; clear pulse emptying the sequence
//   tick        tempo strobe advancing playback
//   out_code    last played entry; out_valid one-cycle strobe qualifying it
//   rec_active  recording; busy playing
//   seq_len     stored entries; full seq_len==DEPTH; overflow sticky dropped-press flag
module pad_sequencer import pad_seq_pkg::*; #(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             pad_code,
    input  logic                   pad_hit,
    input  logic                   rec_en,
    input  logic                   play_req,
    input  logic                   clear,
    input  logic                   tick,
    output logic [3:0]             out_code,
    output logic                   out_valid,
    output logic                   rec_active,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] seq_len,
    output logic                   full,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic          press;
    logic [3:0]    press_code;
    logic          full_w;
    logic [3:0]    mem [DEPTH];

    pad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_hit    (pad_hit),
        .pad_code   (pad_code),
        .press      (press),
        .press_code (press_code)
    );

    assign full_w = (len_q == LW'(DEPTH));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rd_d    = rd_q;
        code_d  = code_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            len_d   = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_en) begin
                        state_d = ST_REC;
                    end else if (play_req && len_q != '0) begin
                        state_d = ST_PLAY;
                        rd_d    = '0;
                    end
                end
                ST_REC: begin
                    if (press) begin
                        if (full_w) begin
                            ovf_d = 1'b1;
                        end else begin
                            we    = 1'b1;
                            len_d = len_q + LW'(1);
                        end
                    end
                    if (!rec_en) state_d = ST_IDLE;
                end
                ST_PLAY: begin
                    if (tick) begin
                        code_d  = mem[rd_q];
                        valid_d = 1'b1;
                        rd_d    = rd_q + AW'(1);
                        // the tick emitting the final entry also ends playback
                        if ({1'b0, rd_q} == len_q - LW'(1)) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rd_q    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // contents are only readable below seq_len, so the array needs no reset
    always_ff @(posedge clk) begin
        if (we) mem[len_q[AW-1:0]] <= press_code;
    end

    assign out_code   = code_q;
    assign out_valid  = valid_q;
    assign rec_active = (state_q == ST_REC);
    assign busy       = (state_q == ST_PLAY);
    assign seq_len    = len_q;
    assign full       = full_w;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_pad_sequencer.sv
// tb_pad_sequencer: directed table-driven and sequence checks for pad_sequencer.
module tb_pad_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pad_code;
    logic       pad_hit, rec_en, play_req, clear, tick;
    logic [3:0] out_code;
    logic       out_valid, rec_active, busy, full, overflow;
    logic [4:0] seq_len;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    pad_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_code   (pad_code),
        .pad_hit    (pad_hit),
        .rec_en     (rec_en),
        .play_req   (play_req),
        .clear      (clear),
        .tick       (tick),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .rec_active (rec_active),
        .busy       (busy),
        .seq_len    (seq_len),
        .full       (full),
        .overflow   (overflow)
    );

    typedef struct {
        logic       rec_en, play_req, clr, tick;
        logic       e_rec, e_busy, e_valid;
        logic [3:0] e_code;
        logic [4:0] e_len;
    } vec_t;

    vec_t t_ctl  [6];
    vec_t t_play [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input int i, input vec_t v);
        rec_en   = v.rec_en;
        play_req = v.play_req;
        clear    = v.clr;
        tick     = v.tick;
        step();
        chk($sformatf("%s[%0d].rec_active", tag, i), 32'(rec_active), 32'(v.e_rec));
        chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.e_busy));
        chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(v.e_valid));
        chk($sformatf("%s[%0d].out_code", tag, i), 32'(out_code), 32'(v.e_code));
        chk($sformatf("%s[%0d].seq_len", tag, i), 32'(seq_len), 32'(v.e_len));
    endtask

    task automatic press_pad(input logic [3:0] c, input int hold, input int gap);
        pad_code = c;
        pad_hit  = 1'b1;
        repeat (hold) step();
        pad_hit  = 1'b0;
        repeat (gap) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_code"}, 32'(out_code), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".rec_active"}, 32'(rec_active), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".seq_len"}, 32'(seq_len), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        int strobes;
        // rec play clr tick | rec busy valid code len ; empty sequence
        t_ctl[0] = '{0, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0};
        t_ctl[1] = '{0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0};
        t_ctl[2] = '{1, 0, 0, 0, 1, 0, 0, 4'd0, 5'd0};
        t_ctl[3] = '{1, 1, 0, 0, 1, 0, 0, 4'd0, 5'd0};
        t_ctl[4] = '{0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd0};
        t_ctl[5] = '{0, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0};
        // playback of 3,7,11 with a tick every 5 cycles
        t_play[0]  = '{0, 1, 0, 0, 0, 1, 0, 4'd0,  5'd3};
        t_play[1]  = '{0, 0, 0, 0, 0, 1, 0, 4'd0,  5'd3};
        t_play[2]  = '{0, 0, 0, 1, 0, 1, 1, 4'd3,  5'd3};
        t_play[3]  = '{0, 0, 0, 0, 0, 1, 0, 4'd3,  5'd3};
        t_play[4]  = '{1, 0, 0, 0, 0, 1, 0, 4'd3,  5'd3};
        t_play[5]  = '{0, 0, 0, 0, 0, 1, 0, 4'd3,  5'd3};
        t_play[6]  = '{0, 0, 0, 0, 0, 1, 0, 4'd3,  5'd3};
        t_play[7]  = '{0, 0, 0, 1, 0, 1, 1, 4'd7,  5'd3};
        t_play[8]  = '{0, 1, 0, 0, 0, 1, 0, 4'd7,  5'd3};
        t_play[9]  = '{0, 0, 0, 0, 0, 1, 0, 4'd7,  5'd3};
        t_play[10] = '{0, 0, 0, 0, 0, 1, 0, 4'd7,  5'd3};
        t_play[11] = '{1, 0, 0, 0, 0, 1, 0, 4'd7,  5'd3};
        t_play[12] = '{1, 0, 0, 1, 0, 0, 1, 4'd11, 5'd3};
        t_play[13] = '{1, 0, 0, 0, 1, 0, 0, 4'd11, 5'd3};
        t_play[14] = '{0, 0, 0, 1, 0, 0, 0, 4'd11, 5'd3};
        t_play[15] = '{0, 1, 0, 0, 0, 1, 0, 4'd11, 5'd3};
        t_play[16] = '{0, 0, 0, 1, 0, 1, 1, 4'd3,  5'd3};
        t_play[17] = '{0, 0, 1, 0, 0, 0, 0, 4'd3,  5'd0};
        t_play[18] = '{0, 0, 0, 1, 0, 0, 0, 4'd3,  5'd0};

        rst_n = 1'b0; pad_code = '0; pad_hit = 1'b0;
        rec_en = 1'b0; play_req = 1'b0; clear = 1'b0; tick = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec("ctl", i, t_ctl[i]);
        rec_en = 1'b0; play_req = 1'b0; clear = 1'b0; tick = 1'b0;
        step();

        // debounce: a 3-cycle pulse is ignored, a held press writes at E7
        rec_en = 1'b1;
        step();
        press_pad(4'd5, 3, 12);
        chk("glitch_len", 32'(seq_len), 0);
        pad_code = 4'd9;
        pad_hit  = 1'b1;
        repeat (6) step();
        chk("deb_e6_len", 32'(seq_len), 0);
        step();
        chk("deb_e7_len", 32'(seq_len), 1);
        repeat (5) step();
        pad_hit = 1'b0;
        repeat (10) step();
        chk("deb_single_len", 32'(seq_len), 1);

        // clear, then record 3,7,11
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_len", 32'(seq_len), 0);
        chk("clear_rec", 32'(rec_active), 0);
        step();
        chk("rec_reenter", 32'(rec_active), 1);
        press_pad(4'd3, 10, 10);
        press_pad(4'd7, 10, 10);
        press_pad(4'd11, 10, 10);
        rec_en = 1'b0;
        step();
        chk("rec3_len", 32'(seq_len), 3);
        for (int i = 0; i < 19; i++) run_vec("play", i, t_play[i]);
        rec_en = 1'b0; play_req = 1'b0; clear = 1'b0; tick = 1'b0;

        // fill to DEPTH and overflow with one extra press
        rec_en = 1'b1;
        step();
        for (int i = 0; i < 16; i++) press_pad(4'(i % 12), 8, 8);
        chk("fill_len", 32'(seq_len), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 0);
        press_pad(4'd10, 8, 8);
        chk("ovf_len", 32'(seq_len), 16);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        rec_en = 1'b0;
        step();
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        chk("full_play_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("full_play[%0d].valid", i), 32'(out_valid), 1);
            chk($sformatf("full_play[%0d].code", i), 32'(out_code), 32'(i % 12));
            step();
        end
        chk("full_play_done", 32'(busy), 0);
        chk("full_kept_ovf", 32'(overflow), 1);

        // clear on the same edge as a press event
        rec_en = 1'b1;
        step();
        pad_code = 4'd4;
        pad_hit  = 1'b1;
        repeat (6) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_press_len", 32'(seq_len), 0);
        chk("clr_press_ovf", 32'(overflow), 0);
        chk("clr_press_full", 32'(full), 0);
        repeat (5) step();
        pad_hit = 1'b0;
        repeat (10) step();
        chk("clr_press_after", 32'(seq_len), 0);

        // reset mid-playback of five entries
        for (int i = 1; i <= 5; i++) press_pad(4'(i), 8, 8);
        chk("rec5_len", 32'(seq_len), 5);
        rec_en = 1'b0;
        step();
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("p5[%0d].code", i), 32'(out_code), 32'(i));
            step();
        end
        step();
        chk("p5_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        step();
        rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 30; k++) begin
            tick = k[0];
            step();
            if (out_valid) strobes++;
        end
        tick = 1'b0;
        chk("post_reset_strobes", 32'(strobes), 0);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_len", 32'(seq_len), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
